ped_request_arbiter: RTL and testbench

- Multi-channel successor to the single-button pedestrian FSM. Each of N_CH crossing buttons must be held for HOLD_CYCLES consecutive cycles to qualify. A qualified button becomes a latched pending request.
- Pending requests are served round-robin over a valid/ready grant handshake to the signal controller. Each accepted grant emits a one-cycle timer load (ld) with the walk-timer select code (sel).
- Sits between the debounced button inputs and the traffic-light controller / timer bank.

---
 rtl/ped_pkg.sv | 21 ++
 rtl/ped_button_channel.sv | 79 +++++++
 rtl/ped_request_arbiter.sv | 98 +++++++++
 tb/tb_ped_request_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ped_pkg.sv
// Shared definitions for the pedestrian request arbiter: channel state
// encoding, timer select codes and a grant index width helper.
package ped_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ARM      = 2'b01,
    PEND     = 2'b11,
    WAIT_REL = 2'b10
  } ch_state_e;

  localparam logic [3:0] SEL_NULL = 4'b0000;
  localparam logic [3:0] SEL_WALK = 4'b0001;
  localparam logic [3:0] SEL_STOP = 4'b1111;

  // Index width for n channels, never less than one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ped_button_channel.sv
// One pedestrian channel: qualifies a held press, latches it as pending until
// its grant is accepted, then waits for release before it can request again.
module ped_button_channel
  import ped_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      button,
  input  logic      grant_accept,
  output logic      button_pressed,
  output logic      pending,
  output ch_state_e state
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_q, pressed_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pressed_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (button) begin
          state_d = ARM;
          cnt_d   = CNT_W'(1);
        end
      end
      ARM: begin
        if (!button) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          // This is the HOLD_CYCLES-th consecutive high sample.
          state_d   = PEND;
          cnt_d     = '0;
          pressed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PEND: begin
        if (grant_accept) begin
          state_d = button ? WAIT_REL : IDLE;
        end
      end
      WAIT_REL: begin
        if (!button) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign button_pressed = pressed_q;
  assign pending        = (state_q == PEND);
  assign state          = state_q;

endmodule

// File: rtl/ped_request_arbiter.sv
// Round-robin arbiter over N_CH pedestrian channels. Grant handshake: grant_ch is
// valid while grant_valid=1 and held until grant_valid & grant_ready at a clk edge.
module ped_request_arbiter
  import ped_pkg::*;
#(
  parameter int                N_CH        = 4,
  parameter int                HOLD_CYCLES = 4,
  parameter int                CNT_W       = 4,
  parameter int                SEL_W       = 4,
  parameter logic [SEL_W-1:0]  SEL_WALK    = ped_pkg::SEL_WALK,
  localparam int               CH_W        = ch_width(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   button,
  input  logic              grant_ready,
  output logic [N_CH-1:0]   button_pressed,
  output logic [N_CH-1:0]   pending,
  output logic              grant_valid,
  output logic [CH_W-1:0]   grant_ch,
  output logic [SEL_W-1:0]  sel,
  output logic              ld
);

  logic             accept;
  logic [N_CH-1:0]  accept_vec;
  logic [N_CH-1:0]  pend_q;
  logic [N_CH-1:0]  req;
  logic [CH_W-1:0]  ptr;
  logic [CH_W-1:0]  next_ptr;
  logic [CH_W-1:0]  pick_ch;
  logic [CH_W-1:0]  idx;
  logic             pick_found;
  ch_state_e        ch_state [N_CH];

  assign accept = grant_valid & grant_ready;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign accept_vec[i] = accept && (grant_ch == CH_W'(i));
    // Only requests that were already pending last cycle compete, which
    // gives a newly qualified channel its grant two cycles after the pulse.
    assign req[i] = pend_q[i] && (ch_state[i] == PEND);

    ped_button_channel #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk            (clk),
      .reset          (reset),
      .button         (button[i]),
      .grant_accept   (accept_vec[i]),
      .button_pressed (button_pressed[i]),
      .pending        (pending[i]),
      .state          (ch_state[i])
    );
  end

  // First requesting channel at or after the pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    idx        = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = CH_W'((int'(ptr) + k) % N_CH);
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_ch    = idx;
      end
    end
  end

  assign next_ptr = (grant_ch == CH_W'(N_CH - 1)) ? '0 : grant_ch + CH_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_valid <= 1'b0;
      grant_ch    <= '0;
      ptr         <= '0;
      pend_q      <= '0;
      ld          <= 1'b0;
      sel         <= '0;
    end else begin
      pend_q <= pending;
      ld     <= accept;
      sel    <= accept ? SEL_WALK : '0;
      if (grant_valid) begin
        if (grant_ready) begin
          grant_valid <= 1'b0;
          ptr         <= next_ptr;
        end
      end else if (pick_found) begin
        grant_valid <= 1'b1;
        grant_ch    <= pick_ch;
      end
    end
  end

endmodule

// File: tb/tb_ped_request_arbiter.sv
// Directed bench for ped_request_arbiter with N_CH=4, HOLD_CYCLES=4: a vector
// table for press/grant basics plus sequences for multi-cycle corner cases.
module tb_ped_request_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] button = 4'b0000;
  logic       grant_ready = 1'b0;
  logic [3:0] button_pressed;
  logic [3:0] pending;
  logic       grant_valid;
  logic [1:0] grant_ch;
  logic [3:0] sel;
  logic       ld;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] b;
    logic       r;
    logic [3:0] pr;
    logic [3:0] pd;
    logic       gv;
    logic [1:0] gch;
    logic       ld;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  ped_request_arbiter #(
    .N_CH        (4),
    .HOLD_CYCLES (4),
    .CNT_W       (4),
    .SEL_W       (4),
    .SEL_WALK    (4'b0001)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .button         (button),
    .grant_ready    (grant_ready),
    .button_pressed (button_pressed),
    .pending        (pending),
    .grant_valid    (grant_valid),
    .grant_ch       (grant_ch),
    .sel            (sel),
    .ld             (ld)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive inputs for the coming edge, then check outputs after it.
  task automatic cyc(input string tag, input logic [3:0] b, input logic r,
                     input logic [3:0] e_pr, input logic [3:0] e_pd,
                     input logic e_gv, input logic [1:0] e_gch, input logic e_ld);
    button      = b;
    grant_ready = r;
    tick();
    check({tag, " button_pressed"}, 32'(button_pressed), 32'(e_pr));
    check({tag, " pending"}, 32'(pending), 32'(e_pd));
    check({tag, " grant_valid"}, 32'(grant_valid), 32'(e_gv));
    if (e_gv) check({tag, " grant_ch"}, 32'(grant_ch), 32'(e_gch));
    check({tag, " ld"}, 32'(ld), 32'(e_ld));
    check({tag, " sel"}, 32'(sel), e_ld ? 32'h1 : 32'h0);
  endtask

  task automatic do_reset(input string tag);
    reset       = 1'b1;
    button      = 4'b0000;
    grant_ready = 1'b0;
    tick();
    check({tag, " button_pressed"}, 32'(button_pressed), 32'h0);
    check({tag, " pending"}, 32'(pending), 32'h0);
    check({tag, " grant_valid"}, 32'(grant_valid), 32'h0);
    check({tag, " grant_ch"}, 32'(grant_ch), 32'h0);
    check({tag, " ld"}, 32'(ld), 32'h0);
    check({tag, " sel"}, 32'(sel), 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Short press on ch0 (3 samples), then a qualified press on ch1 and its grant.
    vecs[0]  = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[2]  = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[3]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[4]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[5]  = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[6]  = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[7]  = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[8]  = '{4'b0010, 1'b0, 4'b0010, 4'b0010, 1'b0, 2'd0, 1'b0};
    vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b0, 2'd0, 1'b0};
    vecs[10] = '{4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0};
    vecs[11] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1};
    vecs[12] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};

    reset = 1'b1;
    tick();
    do_reset("reset");

    for (int i = 0; i < 13; i++) begin
      cyc($sformatf("vec%0d", i), vecs[i].b, vecs[i].r, vecs[i].pr, vecs[i].pd,
          vecs[i].gv, vecs[i].gch, vecs[i].ld);
    end

    // Backpressure: ch2 grant held for 10 cycles of grant_ready=0.
    for (int i = 0; i < 3; i++) cyc("bp arm", 4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    cyc("bp qual", 4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b0, 2'd0, 1'b0);
    cyc("bp wait", 4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 10; i++) cyc("bp hold", 4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0);
    cyc("bp accept", 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1);
    cyc("bp idle", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);

    // Round-robin from pointer 0: ch0, ch2, ch3 qualify together, ready tied high.
    do_reset("rr reset");
    for (int i = 0; i < 3; i++) cyc("rr arm", 4'b1101, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    cyc("rr qual", 4'b1101, 1'b1, 4'b1101, 4'b1101, 1'b0, 2'd0, 1'b0);
    cyc("rr wait", 4'b0000, 1'b1, 4'b0000, 4'b1101, 1'b0, 2'd0, 1'b0);
    cyc("rr g0", 4'b0000, 1'b1, 4'b0000, 4'b1101, 1'b1, 2'd0, 1'b0);
    cyc("rr a0", 4'b0000, 1'b1, 4'b0000, 4'b1100, 1'b0, 2'd0, 1'b1);
    cyc("rr g2", 4'b0000, 1'b1, 4'b0000, 4'b1100, 1'b1, 2'd2, 1'b0);
    cyc("rr a2", 4'b0000, 1'b1, 4'b0000, 4'b1000, 1'b0, 2'd0, 1'b1);
    cyc("rr g3", 4'b0000, 1'b1, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0);
    cyc("rr a3", 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1);
    cyc("rr idle", 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);

    // Pointer wrapped to 0 after ch3: with ch0 and ch3 pending, ch0 goes first.
    for (int i = 0; i < 3; i++) cyc("wrap arm", 4'b1001, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    cyc("wrap qual", 4'b1001, 1'b0, 4'b1001, 4'b1001, 1'b0, 2'd0, 1'b0);
    cyc("wrap wait", 4'b0000, 1'b0, 4'b0000, 4'b1001, 1'b0, 2'd0, 1'b0);
    cyc("wrap g0", 4'b0000, 1'b0, 4'b0000, 4'b1001, 1'b1, 2'd0, 1'b0);
    cyc("wrap a0", 4'b0000, 1'b1, 4'b0000, 4'b1000, 1'b0, 2'd0, 1'b1);
    cyc("wrap g3", 4'b0000, 1'b1, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0);
    cyc("wrap a3", 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1);
    cyc("wrap idle", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);

    // Held button on ch3: no re-request until released and pressed again.
    for (int i = 0; i < 3; i++) cyc("held arm", 4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    cyc("held qual", 4'b1000, 1'b0, 4'b1000, 4'b1000, 1'b0, 2'd0, 1'b0);
    cyc("held wait", 4'b1000, 1'b0, 4'b0000, 4'b1000, 1'b0, 2'd0, 1'b0);
    cyc("held g3", 4'b1000, 1'b0, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0);
    cyc("held acc", 4'b1000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 6; i++) cyc("held wr", 4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    cyc("held rel", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("held rearm", 4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    cyc("held requal", 4'b1000, 1'b0, 4'b1000, 4'b1000, 1'b0, 2'd0, 1'b0);
    cyc("held rewait", 4'b0000, 1'b0, 4'b0000, 4'b1000, 1'b0, 2'd0, 1'b0);
    cyc("held reg3", 4'b0000, 1'b0, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0);
    cyc("held reacc", 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1);
    cyc("held idle", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);

    // Reset while ch0 grant is presented and ch0/ch2 pending.
    for (int i = 0; i < 3; i++) cyc("mid arm", 4'b0101, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    cyc("mid qual", 4'b0101, 1'b0, 4'b0101, 4'b0101, 1'b0, 2'd0, 1'b0);
    cyc("mid wait", 4'b0000, 1'b0, 4'b0000, 4'b0101, 1'b0, 2'd0, 1'b0);
    cyc("mid g0", 4'b0000, 1'b0, 4'b0000, 4'b0101, 1'b1, 2'd0, 1'b0);
    do_reset("mid reset");
    for (int i = 0; i < 3; i++) cyc("post arm", 4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    cyc("post qual", 4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b0, 2'd0, 1'b0);
    cyc("post wait", 4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b0, 2'd0, 1'b0);
    cyc("post g2", 4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0);
    cyc("post acc", 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1);
    cyc("post idle", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
